// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
// Contents:
//   N               - instruction word width (fixed at 32 here)
//   fetch_entry_t   - one buffered fetch result {pc, instr}
//   FETCH_BUF_DEPTH - number of entries in the decode-side buffer
//   PC_STEP         - sequential PC increment in bytes
//   align_pc()      - forces a byte address onto a word boundary
package fetch_pkg;

  localparam int unsigned N = 32;

  typedef struct packed {
    logic [31:0]  pc;
    logic [N-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam logic [31:0] PC_STEP         = 32'd4;

  // Redirect targets may be misaligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   push       - write wr_entry at the tail
//   pop        - retire the head entry
//   flush      - empty the buffer; wins over push and pop
//   wr_entry   - entry to write on push
//   count      - number of valid entries (0..2)
//   head       - entry at the read pointer (meaningful when count != 0)
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [FETCH_BUF_DEPTH];
  fetch_entry_t mem_d [FETCH_BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // A push into a full buffer is legal only when the head leaves in the same
  // cycle; the slot being overwritten is then the one being popped.
  always_comb begin
    do_pop  = pop & (count_q != 2'd0);
    do_push = push & ((count_q < 2'(FETCH_BUF_DEPTH)) | do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: owns the PC, addresses the instruction ROM, captures the
// returned word with its PC and hands {pc, instr} pairs to decode through a
// two-entry buffer. A redirect flushes the buffer and restarts fetch.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   imem_addr      - ROM word address, pc[7:2]
//   imem_q         - ROM data, combinational from imem_addr
//   redirect_valid - restart fetch at redirect_pc this cycle
//   redirect_pc    - redirect target (low two bits ignored)
//   out_valid      - head entry valid
//   out_ready      - decode accepts the head
//   out_pc         - PC of the head entry
//   out_instr      - instruction of the head entry
module fetch_stage #(
  parameter int          N        = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [5:0]   imem_addr,
  input  logic [N-1:0] imem_q,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pc,
  output logic [N-1:0] out_instr
);

  import fetch_pkg::*;

  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         pop, push;

  // A redirect cycle never pushes: the word on imem_q belongs to the path
  // being abandoned. A full buffer still accepts a push when decode pops.
  always_comb begin
    pop  = out_valid & out_ready;
    push = ~redirect_valid & ((count < 2'd2) | pop);

    wr_entry.pc    = pc_q;
    wr_entry.instr = imem_q;

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  assign imem_addr = pc_q[7:2];
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage with a small behavioural ROM attached.
module tb_fetch_stage;

  logic        clk;
  logic        rstN;
  logic [5:0]  imemAddr;
  logic [31:0] imemQ;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [31:0] outInstr;

  int passCount  = 0;
  int totalCount = 0;

  logic [31:0] rom [64];

  fetch_stage #(
    .N        (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rstN),
    .imem_addr      (imemAddr),
    .imem_q         (imemQ),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (outValid),
    .out_ready      (outReady),
    .out_pc         (outPc),
    .out_instr      (outInstr)
  );

  // Combinational ROM, same-cycle data for the presented address.
  assign imemQ = rom[imemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
    outReady      = ready;
    redirectValid = redir;
    redirectPc    = target;
  endtask

  // Advance one clock and settle just after the edge, away from it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    stepCycle();
    stepCycle();
    rstN = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'hC0DE_0000 + 32'(i);
    end
    rom[0]  = 32'h0000_0013;
    rom[2]  = 32'h3004_5073;
    rom[7]  = 32'h3000_2573;
    rom[9]  = 32'h3000_2573;
    rom[10] = 32'hfe00_0ee3;

    // Reset values, then stream with decode always ready.
    applyStimulus(1'b1, 1'b0, 32'h0);
    doReset();
    checkOutput("rst_valid", 32'(outValid), 32'h0);
    checkOutput("rst_pc", outPc, 32'h0);
    checkOutput("rst_instr", outInstr, 32'h0);
    checkOutput("rst_addr", 32'(imemAddr), 32'd0);
    stepCycle();
    checkOutput("c1_valid", 32'(outValid), 32'h1);
    checkOutput("c1_pc", outPc, 32'h0);
    checkOutput("c1_instr", outInstr, 32'h0000_0013);
    stepCycle();
    checkOutput("c2_pc", outPc, 32'h4);
    stepCycle();
    checkOutput("c3_pc", outPc, 32'h8);
    checkOutput("c3_instr", outInstr, 32'h3004_5073);

    // Back-pressure: buffer fills to two, pc holds at 0x08.
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset();
    repeat (5) stepCycle();
    checkOutput("bp_addr", 32'(imemAddr), 32'd2);
    checkOutput("bp_valid", 32'(outValid), 32'h1);
    checkOutput("bp_pc", outPc, 32'h0);
    checkOutput("bp_instr", outInstr, 32'h0000_0013);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rel_pc0", outPc, 32'h0);
    stepCycle();
    checkOutput("rel_valid1", 32'(outValid), 32'h1);
    checkOutput("rel_pc1", outPc, 32'h4);
    checkOutput("rel_instr1", outInstr, 32'hC0DE_0001);
    stepCycle();
    checkOutput("rel_valid2", 32'(outValid), 32'h1);
    checkOutput("rel_pc2", outPc, 32'h8);
    checkOutput("rel_instr2", outInstr, 32'h3004_5073);

    // Redirect to 0x24 with two entries buffered.
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("full_valid", 32'(outValid), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h24);
    stepCycle();
    checkOutput("rd_flush_valid", 32'(outValid), 32'h0);
    checkOutput("rd_addr", 32'(imemAddr), 32'd9);
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rd_valid", 32'(outValid), 32'h1);
    checkOutput("rd_pc", outPc, 32'h24);
    checkOutput("rd_instr", outInstr, 32'h3000_2573);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rd_next_pc", outPc, 32'h28);
    checkOutput("rd_next_instr", outInstr, 32'hfe00_0ee3);

    // Misaligned redirect together with a pop of head 0x28.
    applyStimulus(1'b1, 1'b1, 32'h1e);
    stepCycle();
    checkOutput("mis_flush_valid", 32'(outValid), 32'h0);
    checkOutput("mis_addr", 32'(imemAddr), 32'd7);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("mis_valid", 32'(outValid), 32'h1);
    checkOutput("mis_pc", outPc, 32'h1c);
    checkOutput("mis_instr", outInstr, 32'h3000_2573);

    // Back-to-back redirects, the second one to 0xFC, then PC wrap of the ROM index.
    applyStimulus(1'b1, 1'b1, 32'h40);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'hFC);
    stepCycle();
    checkOutput("b2b_valid", 32'(outValid), 32'h0);
    checkOutput("b2b_addr", 32'(imemAddr), 32'd63);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("wrap_pc0", outPc, 32'hFC);
    checkOutput("wrap_instr0", outInstr, 32'hC0DE_003F);
    checkOutput("wrap_addr0", 32'(imemAddr), 32'd0);
    stepCycle();
    checkOutput("wrap_pc1", outPc, 32'h100);
    checkOutput("wrap_instr1", outInstr, 32'h0000_0013);
    checkOutput("wrap_addr1", 32'(imemAddr), 32'd1);

    // Asynchronous reset with two entries buffered.
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("pre_rst_valid", 32'(outValid), 32'h1);
    checkOutput("pre_rst_pc", outPc, 32'h100);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(outValid), 32'h0);
    checkOutput("arst_pc", outPc, 32'h0);
    checkOutput("arst_addr", 32'(imemAddr), 32'd0);
    stepCycle();
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_valid0", 32'(outValid), 32'h0);
    stepCycle();
    checkOutput("post_rst_valid1", 32'(outValid), 32'h1);
    checkOutput("post_rst_pc", outPc, 32'h0);
    checkOutput("post_rst_instr", outInstr, 32'h0000_0013);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
